// File: rtl/mux_arb.sv
// N-to-1 arbitrated multiplexer with a single registered output slot.
// Each input channel offers a word with valid/ready; one winner per cycle loads the
// output register, which is drained by a downstream valid/ready handshake.
// Optional feature: define MUX_ARB_RR_EN for round-robin arbitration; otherwise the
// lowest-index requesting channel always wins and no pointer register exists.
module mux_arb #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N = 3,
   localparam int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SW-1:0]      out_chan
);

   typedef enum logic {StEmpty, StFull} slot_state_e;

   slot_state_e      state;
   logic             slot_open;
   logic             in_xfer;
   logic             out_xfer;
   logic [N-1:0]     grant;
   logic [SW-1:0]    grant_idx;
   logic [WIDTH-1:0] grant_data;

`ifdef MUX_ARB_RR_EN
   logic [SW-1:0] rr_ptr;
   logic [N-1:0]  upper_req;
   logic [N-1:0]  pick;

   // Round-robin grant: prefer requesters at or above the pointer, else wrap to lowest.
   always_comb begin
      upper_req = in_valid & ({N{1'b1}} << rr_ptr);
      pick      = (|upper_req) ? upper_req : in_valid;
      grant     = pick & (~pick + N'(1));
   end

   // Pointer moves just past the channel that transferred; idle cycles leave it alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (in_xfer) begin
         rr_ptr <= (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
      end
   end
`else
   // Fixed-priority grant: isolate the lowest set request bit.
   always_comb begin
      grant = in_valid & (~in_valid + N'(1));
   end
`endif

   // Encode the one-hot grant into an index and steer the winning word.
   always_comb begin
      grant_idx  = '0;
      grant_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            grant_idx  = SW'(i);
            grant_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Handshake decode; ready depends only on valids and slot state, never on data.
   always_comb begin
      out_valid = (state == StFull);
      out_xfer  = out_valid & out_ready;
      slot_open = ~out_valid | out_ready;
      in_ready  = (reset || !slot_open) ? '0 : grant;
      in_xfer   = |in_ready;
   end

   // Output slot: load on input transfer (also when draining), empty on drain only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= StEmpty;
         out_data <= '0;
         out_chan <= '0;
      end else if (in_xfer) begin
         state    <= StFull;
         out_data <= grant_data;
         out_chan <= grant_idx;
      end else if (out_xfer) begin
         state    <= StEmpty;
      end
   end

endmodule

// File: tb/tb_mux_arb.sv
// Self-checking bench for mux_arb (N=3, WIDTH=8): directed scenarios plus random
// traffic compared against a transaction-level model of the slot and arbiter.
module tb_mux_arb;

   localparam int N = 3;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [N*W-1:0] in_data = '0;
   logic [N-1:0]   in_valid = '0;
   logic [N-1:0]   in_ready;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [1:0]     out_chan;

   int checks = 0;
   int failures = 0;

   // Reference model state
   bit       m_full;
   logic [W-1:0] m_data;
   int       m_chan;
   int       m_ptr;

   mux_arb #(.WIDTH(W), .N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_chan  (out_chan)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Winner channel per the arbitration rule, -1 when nothing requests.
   function automatic int model_grant(input logic [N-1:0] v);
`ifdef MUX_ARB_RR_EN
      for (int k = 0; k < N; k++) begin
         if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
`else
      for (int c = 0; c < N; c++) begin
         if (v[c]) return c;
      end
`endif
      return -1;
   endfunction

   function automatic void model_reset();
      m_full = 1'b0;
      m_data = '0;
      m_chan = 0;
      m_ptr  = 0;
   endfunction

   // One clock: drive at negedge, check, advance model at posedge, return at negedge.
   task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic ordy);
      int g;
      logic [N-1:0] exp_rdy;
      bit open;
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      #1;
      open = !m_full || ordy;
      g = model_grant(v);
      exp_rdy = '0;
      if (open && g >= 0) exp_rdy[g] = 1'b1;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(m_full));
      if (m_full) begin
         check("out_data", 32'(out_data), 32'(m_data));
         check("out_chan", 32'(out_chan), 32'(m_chan));
      end
      @(posedge clk);
      if (exp_rdy != '0) begin
         m_full = 1'b1;
         m_data = d[g*W +: W];
         m_chan = g;
`ifdef MUX_ARB_RR_EN
         m_ptr  = (g + 1) % N;
`endif
      end else if (m_full && ordy) begin
         m_full = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic apply_reset();
      in_valid  = '0;
      out_ready = 1'b0;
      reset     = 1'b1;
      #1;
      model_reset();
      repeat (2) begin
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_out_data", 32'(out_data), 32'd0);
         check("rst_out_chan", 32'(out_chan), 32'd0);
         check("rst_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
      reset = 1'b0;
   endtask

   initial begin
      int exp_seq[5];
      @(negedge clk);

      // Reset then idle
      apply_reset();
      repeat (3) cycle(3'b000, '0, 1'b1);
      check("idle_out_data", 32'(out_data), 32'd0);

      // Single word on channel 1
      cycle(3'b010, {8'h00, 8'h5A, 8'h00}, 1'b1);
      check("single_valid", 32'(out_valid), 32'd1);
      check("single_data", 32'(out_data), 32'h5A);
      check("single_chan", 32'(out_chan), 32'd1);
      cycle(3'b000, '0, 1'b1);

      // All channels requesting, full throughput
      apply_reset();
`ifdef MUX_ARB_RR_EN
      exp_seq = '{0, 1, 2, 0, 1};
`else
      exp_seq = '{0, 0, 0, 0, 0};
`endif
      for (int k = 0; k < 5; k++) begin
         cycle(3'b111, {8'h12, 8'h11, 8'h10}, 1'b1);
         check("seq_chan", 32'(out_chan), 32'(exp_seq[k]));
         check("seq_data", 32'(out_data), 32'h10 + 32'(exp_seq[k]));
`ifndef MUX_ARB_RR_EN
         check("fp_ready_hi", 32'(in_ready[2:1]), 32'd0);
`endif
      end

      // Back-pressure
      apply_reset();
      cycle(3'b001, {8'h00, 8'h00, 8'h11}, 1'b1);
      for (int k = 0; k < 4; k++) begin
         cycle(3'b110, {8'h44, 8'h22, 8'h00}, 1'b0);
         check("bp_data", 32'(out_data), 32'h11);
         check("bp_ready", 32'(in_ready), 32'd0);
      end
      cycle(3'b110, {8'h44, 8'h22, 8'h00}, 1'b1);
      check("bp_next_data", 32'(out_data), 32'h22);
      check("bp_next_chan", 32'(out_chan), 32'd1);

      // Mid-operation reset between edges
      cycle(3'b010, {8'h00, 8'h33, 8'h00}, 1'b1);
      cycle(3'b000, '0, 1'b0);
      check("pre_rst_data", 32'(out_data), 32'h33);
      in_valid  = 3'b111;
      out_ready = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_data", 32'(out_data), 32'd0);
      check("midrst_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("midrst_ready2", 32'(in_ready), 32'd0);
      reset = 1'b0;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         cycle(3'b000, '0, 1'b1);
         check("no_stale_33", 32'(out_data == 8'h33), 32'd0);
      end
      cycle(3'b100, {8'hAB, 8'h00, 8'h00}, 1'b1);
      check("post_rst_data", 32'(out_data), 32'hAB);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         cycle(3'($urandom), 24'($urandom), ($urandom_range(0, 3) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
